ir_packet_encoder: RTL and testbench

Per-car IR packet encoder, directly downstream of the IR bus peripheral's SEND_PACKET/COMMAND registers; one instance per car colour, output muxed onto IR_LED.
- On a SEND_PACKET pulse, latches the 4-bit command.
- Emits one packet as carrier-modulated bursts in this order: start, car-select, right, left, backward, forward.
- Each burst is followed by a gap.
- Reports BUSY while transmitting and pulses DONE when finished.

---
 rtl/ir_packet_if.sv | 24 ++
 rtl/ir_packet_encoder.sv | 201 ++++++++++++++++++++
 tb/tb_ir_packet_encoder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ir_packet_if.sv
// Request/command/status bundle between the IR bus peripheral and one packet encoder.
interface ir_packet_if;
  logic       SEND_PACKET;
  logic [3:0] COMMAND;
  logic       IR_LED;
  logic       BUSY;
  logic       DONE;

  modport master (
    output SEND_PACKET,
    output COMMAND,
    input  IR_LED,
    input  BUSY,
    input  DONE
  );

  modport slave (
    input  SEND_PACKET,
    input  COMMAND,
    output IR_LED,
    output BUSY,
    output DONE
  );
endinterface

// File: rtl/ir_packet_encoder.sv
// Per-car IR packet encoder: start/car-select/command-bit carrier bursts, each followed by a gap.
// Optional macro IR_PENDING_EN adds a one-deep pending request queued while a packet is in flight.
module ir_packet_encoder #(
  parameter int unsigned CARRIER_HALF   = 694,
  parameter int unsigned START_BURST    = 88,
  parameter int unsigned CARSEL_BURST   = 22,
  parameter int unsigned GAP_SIZE       = 40,
  parameter int unsigned ASSERT_BURST   = 44,
  parameter int unsigned DEASSERT_BURST = 22
) (
  input  logic        CLK,
  input  logic        RESET,
  ir_packet_if.slave  bus
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned CMD_W     = 4;
  localparam int unsigned MAX_BURST = max2(max2(max2(START_BURST, CARSEL_BURST), GAP_SIZE),
                                           max2(ASSERT_BURST, DEASSERT_BURST));
  localparam int unsigned HALF_W    = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam int unsigned PER_W     = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    GAP    = 3'd2,
    CARSEL = 3'd3,
    RIGHT  = 3'd4,
    LEFT   = 3'd5,
    BACK   = 3'd6,
    FWD    = 3'd7
  } state_e;

  state_e              state_q, state_d;
  state_e              next_q, next_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic                carrier_q, carrier_d;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept_c;
  logic [CMD_W-1:0]    accept_cmd_c;
  logic [PER_W-1:0]    burst_len_c;
  logic                half_wrap_c;
  logic                period_end_c;

  function automatic state_e burst_after(input state_e s);
    case (s)
      START:   return CARSEL;
      CARSEL:  return RIGHT;
      RIGHT:   return LEFT;
      LEFT:    return BACK;
      BACK:    return FWD;
      default: return IDLE;
    endcase
  endfunction

`ifdef IR_PENDING_EN
  logic             pend_q, pend_d;
  logic [CMD_W-1:0] pend_cmd_q, pend_cmd_d;

  // In IDLE a held request wins and a simultaneous new one takes its slot; otherwise
  // requests arriving mid-packet overwrite the slot (last wins).
  always_comb begin
    pend_d       = pend_q;
    pend_cmd_d   = pend_cmd_q;
    accept_c     = bus.SEND_PACKET;
    accept_cmd_c = bus.COMMAND;
    if (state_q == IDLE) begin
      if (pend_q) begin
        accept_c     = 1'b1;
        accept_cmd_c = pend_cmd_q;
        pend_d       = bus.SEND_PACKET;
        if (bus.SEND_PACKET) pend_cmd_d = bus.COMMAND;
      end
    end else if (bus.SEND_PACKET) begin
      pend_d     = 1'b1;
      pend_cmd_d = bus.COMMAND;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q     <= 1'b0;
      pend_cmd_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cmd_q <= pend_cmd_d;
    end
  end
`else
  always_comb begin
    accept_c     = bus.SEND_PACKET;
    accept_cmd_c = bus.COMMAND;
  end
`endif

  // Number of carrier periods for the current state (gap length while in GAP).
  always_comb begin
    burst_len_c = PER_W'(GAP_SIZE);
    case (state_q)
      START:   burst_len_c = PER_W'(START_BURST);
      CARSEL:  burst_len_c = PER_W'(CARSEL_BURST);
      RIGHT:   burst_len_c = cmd_q[0] ? PER_W'(ASSERT_BURST) : PER_W'(DEASSERT_BURST);
      LEFT:    burst_len_c = cmd_q[1] ? PER_W'(ASSERT_BURST) : PER_W'(DEASSERT_BURST);
      BACK:    burst_len_c = cmd_q[2] ? PER_W'(ASSERT_BURST) : PER_W'(DEASSERT_BURST);
      FWD:     burst_len_c = cmd_q[3] ? PER_W'(ASSERT_BURST) : PER_W'(DEASSERT_BURST);
      default: burst_len_c = PER_W'(GAP_SIZE);
    endcase
  end

  // Periods are counted on falling carrier edges; a burst or gap ends at the wrap that
  // closes the low half of its last period, so the output is low at the boundary.
  assign half_wrap_c  = (half_q == HALF_W'(CARRIER_HALF - 1));
  assign period_end_c = half_wrap_c && !carrier_q && (per_q == burst_len_c);

  always_comb begin
    state_d   = state_q;
    next_d    = next_q;
    cmd_d     = cmd_q;
    half_d    = half_q;
    per_d     = per_q;
    carrier_d = carrier_q;
    led_d     = led_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (state_q == IDLE) begin
      if (accept_c) begin
        cmd_d     = accept_cmd_c;
        state_d   = START;
        next_d    = IDLE;
        half_d    = '0;
        per_d     = '0;
        carrier_d = 1'b1;
        led_d     = 1'b1;
        busy_d    = 1'b1;
      end
    end else begin
      half_d = half_wrap_c ? '0 : half_q + HALF_W'(1);
      if (half_wrap_c) carrier_d = ~carrier_q;
      if (half_wrap_c && carrier_q) per_d = per_q + PER_W'(1);
      led_d = (state_q == GAP) ? 1'b0 : carrier_d;

      if (period_end_c) begin
        half_d    = '0;
        per_d     = '0;
        carrier_d = 1'b1;
        if (state_q != GAP) begin
          state_d = GAP;
          next_d  = burst_after(state_q);
          led_d   = 1'b0;
        end else if (next_q == IDLE) begin
          state_d   = IDLE;
          carrier_d = 1'b0;
          led_d     = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          state_d = next_q;
          led_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      next_q    <= IDLE;
      cmd_q     <= '0;
      half_q    <= '0;
      per_q     <= '0;
      carrier_q <= 1'b0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      next_q    <= next_d;
      cmd_q     <= cmd_d;
      half_q    <= half_d;
      per_q     <= per_d;
      carrier_q <= carrier_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.IR_LED = led_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;

endmodule

// File: tb/tb_ir_packet_encoder.sv
// Directed bench for ir_packet_encoder with a small packet geometry; expected LED waveform
// is built from the packet format, not from the design.
module tb_ir_packet_encoder;

  localparam int unsigned H  = 2;
  localparam int unsigned SB = 4;
  localparam int unsigned CB = 2;
  localparam int unsigned GB = 1;
  localparam int unsigned AB = 3;
  localparam int unsigned DB = 1;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  ir_packet_if bus();

  ir_packet_encoder #(
    .CARRIER_HALF  (H),
    .START_BURST   (SB),
    .CARSEL_BURST  (CB),
    .GAP_SIZE      (GB),
    .ASSERT_BURST  (AB),
    .DEASSERT_BURST(DB)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit exp_led[$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic add_burst(input int unsigned n);
    for (int p = 0; p < int'(n); p++) begin
      for (int h = 0; h < int'(H); h++) exp_led.push_back(1'b1);
      for (int h = 0; h < int'(H); h++) exp_led.push_back(1'b0);
    end
  endtask

  task automatic add_gap();
    for (int c = 0; c < int'(2 * GB * H); c++) exp_led.push_back(1'b0);
  endtask

  task automatic build_expected(input logic [3:0] cmd);
    exp_led.delete();
    add_burst(SB); add_gap();
    add_burst(CB); add_gap();
    for (int b = 0; b < 4; b++) begin
      add_burst(cmd[b] ? AB : DB);
      add_gap();
    end
  endtask

  // Sends one request, then watches packet length + 4 cycles sampling on the falling edge.
  task automatic run_packet(input string tag, input logic [3:0] cmd, input int change_at,
                            input logic [3:0] new_cmd, input int req_at, input int exp_len,
                            input int exp_busy);
    int len, bad, first_bad, busy_n, done_n, done_at;
    build_expected(cmd);
    len = exp_led.size();
    bad = 0; first_bad = -1; busy_n = 0; done_n = 0; done_at = -1;
    check({tag, "_model_len"}, len, exp_len);
    @(negedge CLK);
    bus.SEND_PACKET = 1'b1;
    bus.COMMAND     = cmd;
    @(negedge CLK);
    bus.SEND_PACKET = 1'b0;
    for (int i = 0; i < len + 4; i++) begin
      if (i < len && bus.IR_LED !== exp_led[i]) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
      if (bus.BUSY === 1'b1) busy_n++;
      if (bus.DONE === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (change_at >= 0 && i >= change_at) bus.COMMAND = new_cmd;
      bus.SEND_PACKET = (i == req_at);
      @(negedge CLK);
    end
    bus.SEND_PACKET = 1'b0;
    check({tag, "_led_bad_cycles"}, bad, 0);
    if (bad != 0) $display("  first LED difference at cycle %0d", first_bad);
    check({tag, "_busy_cycles"}, busy_n, exp_busy);
    check({tag, "_done_pulses"}, done_n, 1);
    check({tag, "_done_cycle"}, done_at, len);
  endtask

  initial begin
    int busy_n, led_n, done_n;
    RESET           = 1'b1;
    bus.SEND_PACKET = 1'b0;
    bus.COMMAND     = 4'b0000;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("reset_led",  int'(bus.IR_LED), 0);
    check("reset_busy", int'(bus.BUSY),   0);
    check("reset_done", int'(bus.DONE),   0);

    // 1: mixed bits, bursts 16,8,12,4,12,4 with 4-cycle gaps
    run_packet("cmd0101", 4'b0101, -1, 4'b0000, -1, 80, 80);
    // 2: all bits clear
    run_packet("cmd0000", 4'b0000, -1, 4'b0000, -1, 64, 64);
    // 3: all bits set, command changed mid-packet must not matter
    run_packet("cmd1111_chg", 4'b1111, 10, 4'b0000, -1, 96, 96);

    // 4: reset 20 cycles into a packet
    @(negedge CLK);
    bus.SEND_PACKET = 1'b1;
    bus.COMMAND     = 4'b0101;
    @(negedge CLK);
    bus.SEND_PACKET = 1'b0;
    repeat (20) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("midreset_led",  int'(bus.IR_LED), 0);
    check("midreset_busy", int'(bus.BUSY),   0);
    check("midreset_done", int'(bus.DONE),   0);
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.BUSY === 1'b1) busy_n++;
      if (bus.DONE === 1'b1) done_n++;
      @(negedge CLK);
    end
    check("midreset_quiet_busy", busy_n, 0);
    check("midreset_quiet_done", done_n, 0);
    run_packet("after_reset", 4'b0101, -1, 4'b0000, -1, 80, 80);

    // 5: second request at cycle 30 of a packet
`ifdef IR_PENDING_EN
    run_packet("req_while_busy", 4'b0101, -1, 4'b0000, 30, 80, 83);
`else
    run_packet("req_while_busy", 4'b0101, -1, 4'b0000, 30, 80, 80);
`endif

    // 6: request and reset in the same cycle
    @(negedge CLK);
    RESET           = 1'b1;
    bus.SEND_PACKET = 1'b1;
    bus.COMMAND     = 4'b1111;
    @(negedge CLK);
    RESET           = 1'b0;
    bus.SEND_PACKET = 1'b0;
    busy_n = 0; led_n = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.BUSY === 1'b1) busy_n++;
      if (bus.IR_LED === 1'b1) led_n++;
      @(negedge CLK);
    end
    check("rst_and_req_busy", busy_n, 0);
    check("rst_and_req_led",  led_n,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
